ttc_counter_lite25: RTL

- Single timer/counter channel of the TTC; produces the event pulses consumed by the TTC interrupt register block: interval_intr25, match_intr25[3:1], overflow_intr25, restart25.
- Holds its own control, prescaler, interval and three match registers, written via per-register select strobes from the APB decode.
- One clock, no CDC.

---
 rtl/ttc_counter_lite25.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ttc_counter_lite25.sv
// Single TTC timer/counter channel: prescaler, free-run/interval count up or down,
// three match comparators and registered single-cycle event pulses.
module ttc_counter_lite25 #(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned PRESCALE_WIDTH = 4
) (
    input  logic                      pclk25,
    input  logic                      n_p_reset25,
    input  logic [CNT_WIDTH-1:0]      pwdata25,
    input  logic                      clk_ctrl_reg_sel25,
    input  logic                      cntr_ctrl_reg_sel25,
    input  logic                      interval_reg_sel25,
    input  logic                      match_1_reg_sel25,
    input  logic                      match_2_reg_sel25,
    input  logic                      match_3_reg_sel25,
    output logic [CNT_WIDTH-1:0]      counter_val25,
    output logic [4:0]                cntr_ctrl_out25,
    output logic [PRESCALE_WIDTH:0]   clk_ctrl_out25,
    output logic                      interval_intr25,
    output logic [3:1]                match_intr25,
    output logic                      overflow_intr25,
    output logic                      restart25
);

    localparam int unsigned PRE_W = 2 ** PRESCALE_WIDTH;

    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [CNT_WIDTH-1:0]    interval_q, interval_d;
    logic [CNT_WIDTH-1:0]    match1_q, match1_d;
    logic [CNT_WIDTH-1:0]    match2_q, match2_d;
    logic [CNT_WIDTH-1:0]    match3_q, match3_d;
    logic [3:0]              ctrl_q, ctrl_d;
    logic [PRESCALE_WIDTH:0] clk_ctrl_q, clk_ctrl_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic                    intr_q, intr_d;
    logic [3:1]              match_intr_q, match_intr_d;
    logic                    ovf_q, ovf_d;
    logic                    restart_q, restart_d;

    logic [PRE_W-1:0]        pre_mask_c;
    logic                    restart_c;
    logic                    tick_c;
    logic                    run_c;

    // Next-state: register writes land this edge, counting uses pre-write values
    always_comb begin
        count_d      = count_q;
        interval_d   = interval_q;
        match1_d     = match1_q;
        match2_d     = match2_q;
        match3_d     = match3_q;
        ctrl_d       = ctrl_q;
        clk_ctrl_d   = clk_ctrl_q;
        pre_d        = pre_q;
        intr_d       = 1'b0;
        match_intr_d = 3'b000;
        ovf_d        = 1'b0;
        restart_d    = 1'b0;

        restart_c  = cntr_ctrl_reg_sel25 && pwdata25[4];
        pre_mask_c = (PRE_W'(1) << (32'(clk_ctrl_q[PRESCALE_WIDTH:1]) + 32'd1)) - PRE_W'(1);
        tick_c     = !clk_ctrl_q[0] || ((pre_q & pre_mask_c) == pre_mask_c);
        run_c      = !ctrl_q[0];

        if (clk_ctrl_reg_sel25)  clk_ctrl_d = pwdata25[PRESCALE_WIDTH:0];
        if (cntr_ctrl_reg_sel25) ctrl_d     = pwdata25[3:0];
        if (interval_reg_sel25)  interval_d = pwdata25;
        if (match_1_reg_sel25)   match1_d   = pwdata25;
        if (match_2_reg_sel25)   match2_d   = pwdata25;
        if (match_3_reg_sel25)   match3_d   = pwdata25;

        if (restart_c) begin
            // Start value follows the newly written mode bits
            if (!pwdata25[2])     count_d = '0;
            else if (pwdata25[1]) count_d = interval_q;
            else                  count_d = '1;
            pre_d     = '0;
            restart_d = 1'b1;
        end else begin
            if (clk_ctrl_q[0] && run_c) pre_d = pre_q + PRE_W'(1);
            if (tick_c && run_c) begin
                if (!ctrl_q[2]) begin
                    if (ctrl_q[1] && (count_q == interval_q)) begin
                        count_d = '0;
                        intr_d  = 1'b1;
                    end else begin
                        count_d = count_q + CNT_WIDTH'(1);
                        ovf_d   = (count_q == '1);
                    end
                end else begin
                    if (ctrl_q[1] && (count_q == '0)) begin
                        count_d = interval_q;
                        intr_d  = 1'b1;
                    end else begin
                        count_d = count_q - CNT_WIDTH'(1);
                        ovf_d   = !ctrl_q[1] && (count_q == '0);
                    end
                end
                if (ctrl_q[3]) begin
                    match_intr_d = {count_d == match3_q, count_d == match2_q, count_d == match1_q};
                end
            end
        end
    end

    always_ff @(posedge pclk25 or negedge n_p_reset25) begin
        if (!n_p_reset25) begin
            count_q      <= '0;
            interval_q   <= '0;
            match1_q     <= '0;
            match2_q     <= '0;
            match3_q     <= '0;
            ctrl_q       <= 4'b0001;
            clk_ctrl_q   <= '0;
            pre_q        <= '0;
            intr_q       <= 1'b0;
            match_intr_q <= 3'b000;
            ovf_q        <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            interval_q   <= interval_d;
            match1_q     <= match1_d;
            match2_q     <= match2_d;
            match3_q     <= match3_d;
            ctrl_q       <= ctrl_d;
            clk_ctrl_q   <= clk_ctrl_d;
            pre_q        <= pre_d;
            intr_q       <= intr_d;
            match_intr_q <= match_intr_d;
            ovf_q        <= ovf_d;
            restart_q    <= restart_d;
        end
    end

    assign counter_val25   = count_q;
    assign cntr_ctrl_out25 = {1'b0, ctrl_q};
    assign clk_ctrl_out25  = clk_ctrl_q;
    assign interval_intr25 = intr_q;
    assign match_intr25    = match_intr_q;
    assign overflow_intr25 = ovf_q;
    assign restart25       = restart_q;

endmodule
